// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between two requesters, A and B.
// A request is acknowledged combinationally in the cycle it wins arbitration.
// Its destination, data and source select appear on the registered write-port
// outputs one cycle later. A write to register 0 is acknowledged and its
// payload is captured, but the write enable stays low for that write.
//
// Build option:
//   WB_ARB_ROUND_ROBIN_EN defined   -> a one-bit priority pointer alternates
//                                      the winner whenever both requesters
//                                      contend in the same cycle.
//   WB_ARB_ROUND_ROBIN_EN undefined -> fixed priority. A always wins on
//                                      contention, and B is granted only in
//                                      cycles where A is not requesting.
module wb_port_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic [4:0]  reg_a,
    input  logic [31:0] data_a,
    output logic        ack_a,
    input  logic        req_b,
    input  logic [4:0]  reg_b,
    input  logic [31:0] data_b,
    output logic        ack_b,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        sel
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic   grant_a;
    logic   grant_b;

`ifdef WB_ARB_ROUND_ROBIN_EN
    // prio_b high means B wins the next contended cycle; reset favours A
    logic   prio_b;

    // Round-robin arbitration, masked while reset is asserted so no ack escapes
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n) begin
            grant_a = req_a && (!req_b || !prio_b);
            grant_b = req_b && (!req_a ||  prio_b);
        end
    end

    // Pointer hands priority to the loser of each grant, holds when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b <= 1'b0;
        end else if (grant_a) begin
            prio_b <= 1'b1;
        end else if (grant_b) begin
            prio_b <= 1'b0;
        end
    end
`else
    // Fixed priority: A always wins, B only gets the port when A is quiet
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n) begin
            grant_a = req_a;
            grant_b = req_b && !req_a;
        end
    end
`endif

    assign ack_a = grant_a;
    assign ack_b = grant_b;

    // Next state follows this cycle's grant, so back-to-back writes need no gap
    always_comb begin
        next_state = IDLE;
        if (grant_a) begin
            next_state = WR_A;
        end else if (grant_b) begin
            next_state = WR_B;
        end
    end

    // State register records which requester's write is on the port now
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the winner's payload at the grant edge and hold it through idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_reg  <= 5'd0;
            write_data <= 32'd0;
            sel        <= 1'b0;
        end else if (grant_a) begin
            write_reg  <= reg_a;
            write_data <= data_a;
            sel        <= 1'b0;
        end else if (grant_b) begin
            write_reg  <= reg_b;
            write_data <= data_b;
            sel        <= 1'b1;
        end
    end

    // Write enable depends only on registers. It is high only in a write state
    // and only when the destination is a real register (not register 0).
    assign reg_write = (state != IDLE) && (write_reg != 5'd0);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// Directed, table-driven bench for wb_port_arbiter, with hand-written sequences
// for reset behaviour and payload changes while a requester is held off.
// Expected values adapt to the WB_ARB_ROUND_ROBIN_EN build option.
module tb_wb_port_arbiter;

`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_a;
    logic [4:0]  reg_a;
    logic [31:0] data_a;
    logic        ack_a;
    logic        req_b;
    logic [4:0]  reg_b;
    logic [31:0] data_b;
    logic        ack_b;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        sel;

    int testsRun;
    int testsFailed;

    typedef struct {
        logic        reqA;
        logic [4:0]  regA;
        logic [31:0] dataA;
        logic        reqB;
        logic [4:0]  regB;
        logic [31:0] dataB;
        logic        expAckA;
        logic        expAckB;
        logic        expRegWrite;
        logic [4:0]  expWriteReg;
        logic [31:0] expWriteData;
        logic        expSel;
    } vector_t;

    vector_t vec [10];

    wb_port_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_a      (req_a),
        .reg_a      (reg_a),
        .data_a     (data_a),
        .ack_a      (ack_a),
        .req_b      (req_b),
        .reg_b      (reg_b),
        .data_b     (data_b),
        .ack_b      (ack_b),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .sel        (sel)
    );

    // Free-running clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vector_t mkVec(
        logic ra, logic [4:0] ga, logic [31:0] da,
        logic rb, logic [4:0] gb, logic [31:0] db,
        logic eaa, logic eab, logic erw, logic [4:0] ewr, logic [31:0] ewd, logic es);
        vector_t v;
        v.reqA = ra;  v.regA = ga;  v.dataA = da;
        v.reqB = rb;  v.regB = gb;  v.dataB = db;
        v.expAckA = eaa;  v.expAckB = eab;  v.expRegWrite = erw;
        v.expWriteReg = ewr;  v.expWriteData = ewd;  v.expSel = es;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkPort(input string tag, input logic erw, input logic [4:0] ewr,
                             input logic [31:0] ewd, input logic es);
        checkOutput({tag, " reg_write"},  {31'd0, reg_write}, {31'd0, erw});
        checkOutput({tag, " write_reg"},  {27'd0, write_reg}, {27'd0, ewr});
        checkOutput({tag, " write_data"}, write_data, ewd);
        checkOutput({tag, " sel"},        {31'd0, sel}, {31'd0, es});
    endtask

    // Called at posedge+1: drive inputs, check acks mid-cycle, check port after the edge
    task automatic applyStimulus(input vector_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        req_a = v.reqA;  reg_a = v.regA;  data_a = v.dataA;
        req_b = v.reqB;  reg_b = v.regB;  data_b = v.dataB;
        #4;
        checkOutput({tag, " ack_a"}, {31'd0, ack_a}, {31'd0, v.expAckA});
        checkOutput({tag, " ack_b"}, {31'd0, ack_b}, {31'd0, v.expAckB});
        @(posedge clk);
        #1;
        checkPort(tag, v.expRegWrite, v.expWriteReg, v.expWriteData, v.expSel);
    endtask

    task automatic resetPulse();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        // Table: starts right after reset, so priority favours A
        vec[0] = mkVec(1, 5'd5, 32'h1234, 0, 5'd0, 32'h0,
                       1, 0, 1, 5'd5, 32'h1234, 0);
        vec[1] = mkVec(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                       0, 0, 0, 5'd5, 32'h1234, 0);
        vec[2] = mkVec(0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF,
                       0, 1, 0, 5'd0, 32'hFFFF, 1);
        vec[3] = mkVec(1, 5'd3, 32'h33, 1, 5'd7, 32'h77,
                       1, 0, 1, 5'd3, 32'h33, 0);
        vec[4] = RR ? mkVec(1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 0, 1, 1, 5'd7, 32'h77, 1)
                    : mkVec(1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 1, 0, 1, 5'd3, 32'h33, 0);
        vec[5] = mkVec(1, 5'd3, 32'h33, 1, 5'd7, 32'h77,
                       1, 0, 1, 5'd3, 32'h33, 0);
        vec[6] = RR ? mkVec(1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 0, 1, 1, 5'd7, 32'h77, 1)
                    : mkVec(1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 1, 0, 1, 5'd3, 32'h33, 0);
        vec[7] = mkVec(0, 5'd0, 32'h0, 1, 5'd9, 32'h99,
                       0, 1, 1, 5'd9, 32'h99, 1);
        vec[8] = mkVec(1, 5'd0, 32'h5, 0, 5'd0, 32'h0,
                       1, 0, 0, 5'd0, 32'h5, 0);
        vec[9] = mkVec(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                       0, 0, 0, 5'd0, 32'h5, 0);

        // Reset with both requests high: acks stay low and the port clears
        rst_n  = 1'b0;
        req_a  = 1'b1;  reg_a = 5'd4;  data_a = 32'hAAAA;
        req_b  = 1'b1;  reg_b = 5'd6;  data_b = 32'hBBBB;
        @(posedge clk);
        #1;
        checkOutput("reset ack_a", {31'd0, ack_a}, 32'd0);
        checkOutput("reset ack_b", {31'd0, ack_b}, 32'd0);
        checkPort("reset", 1'b0, 5'd0, 32'd0, 1'b0);
        req_a = 1'b0;
        req_b = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vec[i], i);
        end

        // Reset asserted mid-write clears the port at once; the held request is re-granted
        req_a = 1'b1;  reg_a = 5'd5;  data_a = 32'h1234;
        req_b = 1'b0;
        @(posedge clk);
        #1;
        checkPort("midwrite pre", 1'b1, 5'd5, 32'h1234, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkPort("midwrite async", 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("midwrite ack_a in reset", {31'd0, ack_a}, 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("midwrite ack_a after release", {31'd0, ack_a}, 32'd1);
        @(posedge clk);
        #1;
        checkPort("midwrite reissue", 1'b1, 5'd5, 32'h1234, 1'b0);

        // B held off under contention while its data changes; the value at its grant edge is written
        req_a = 1'b0;
        req_b = 1'b0;
        resetPulse();
        req_a = 1'b1;  reg_a = 5'd1;  data_a = 32'h11;
        req_b = 1'b1;  reg_b = 5'd2;  data_b = 32'h22;
        #4;
        checkOutput("holdoff ack_a", {31'd0, ack_a}, 32'd1);
        checkOutput("holdoff ack_b", {31'd0, ack_b}, 32'd0);
        @(posedge clk);
        #1;
        checkPort("holdoff A write", 1'b1, 5'd1, 32'h11, 1'b0);
        req_a  = 1'b0;
        data_b = 32'h44;
        #4;
        checkOutput("holdoff ack_b granted", {31'd0, ack_b}, 32'd1);
        @(posedge clk);
        #1;
        checkPort("holdoff B write", 1'b1, 5'd2, 32'h44, 1'b1);
        req_b = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst  input  1  asynchronous active-low reset.
REQ-004 ReqA  input  1  requester A write request; held with RegA/DataA until accepted.
REQ-005 RegA  input  5  requester A destination register.
REQ-006 DataA  input  32  requester A write data.
REQ-007 AckA  output  1  combinational; high in the cycle A is granted; transfer occurs at the edge where ReqA&AckA.
REQ-008 ReqB, RegB, DataB, AckB  as REQ-004..007 for requester B.
REQ-009 RegWrite  output  1  registered register-file write enable.
REQ-010 WriteReg  output  5  registered destination; drives the RegDst-style 5-bit 2:1 mux path.
REQ-011 WriteData  output  32  registered write data.
REQ-012 Sel  output  1  registered source select for the 5-bit 2:1 mux; 0 = A, 1 = B.

Function
REQ-013 The block SHALL own the single register-file write port and share it between requesters A and B, granting at most one per cycle.
REQ-014 FSM states: IDLE (no write issued), WR_A (A's write on outputs), WR_B (B's write on outputs); the next state is decided every cycle from the requests, with no dead cycle between back-to-back grants.
REQ-015 Transitions: no request -> IDLE; grant A -> WR_A; grant B -> WR_B; allowed from any state.
REQ-016 Priority pointer (1 bit): after a grant to A, B has priority; after a grant to B, A has priority; unchanged in cycles with no grant.
REQ-017 Only ReqA -> AckA=1; only ReqB -> AckB=1; both -> Ack to the pointer's favoured requester only; AckA and AckB SHALL never both be high.
REQ-018 Ack SHALL be 0 whenever the matching Req is 0.
REQ-019 Latency: a request granted in cycle N appears on RegWrite/WriteReg/WriteData/Sel in cycle N+1, exactly one cycle.
REQ-020 A granted write with Reg = 0 SHALL be acknowledged but produce RegWrite=0 in N+1; WriteReg/WriteData/Sel still update.
REQ-021 In IDLE, RegWrite=0; WriteReg, WriteData and Sel SHALL hold their last values.
REQ-022 A requester held off by contention SHALL be granted within 2 cycles while its Req stays high (round-robin build).
REQ-023 Payload changes while Req is high and Ack is low SHALL be tolerated; the value sampled at the grant edge is written.

Reset
REQ-024 While Rst=0: state=IDLE, pointer favours A, RegWrite=0, WriteReg=5'd0, WriteData=32'd0, Sel=0, AckA=AckB=0, regardless of Req inputs.
REQ-025 Reset asserted mid-write SHALL clear outputs immediately (asynchronously); a request pending at reset SHALL not be considered transferred and must be re-granted after release.
REQ-026 The first edge after Rst deasserts SHALL evaluate requests normally.

Configuration
REQ-027 Macro WB_ARB_ROUND_ROBIN_EN: defined -> round-robin priority per REQ-016/022.
REQ-028 WB_ARB_ROUND_ROBIN_EN undefined -> fixed priority, A always wins on contention; the pointer is not implemented; B is granted only in cycles with ReqA=0; REQ-022 does not apply.

Verification
REQ-029 Reset, ReqA=1 RegA=5 DataA=32'h1234 -> AckA=1 in that cycle; next cycle RegWrite=1 WriteReg=5 WriteData=32'h1234 Sel=0.
REQ-030 ReqA=ReqB=1 held 4 cycles (RegA=3, RegB=7), round-robin build -> grants A,B,A,B; RegWrite=1 each following cycle, WriteReg 3,7,3,7, Sel 0,1,0,1.
REQ-031 Same stimulus, macro undefined -> AckA=1 all 4 cycles, AckB=0; WriteReg=3 throughout.
REQ-032 ReqB=1 RegB=0 DataB=32'hFFFF -> AckB=1; next cycle RegWrite=0, WriteReg=0, Sel=1.
REQ-033 ReqA=1 granted, Rst driven low mid-cycle before next edge -> RegWrite, WriteReg, WriteData, Sel go 0 immediately; after release with ReqA still high -> AckA=1, write reissued one cycle later.
